// File: rtl/lcd_dma_read_arbiter.sv
`timescale 1ns/1ps
// Purpose : shares one burst-read DMA port between the LCD framebuffer fetch (req 0)
//           and a secondary fetch client (req 1); one burst in flight at a time.
// Latency : START latched at edge k -> DMA_START high after edge k+1 (DMA idle, req wins).
// Backpr. : REQn_READY low from the latch edge until that requester's burst completes;
//           a new grant waits for DMA_READY=1 and never issues in the completion cycle.
//
// Ports
//   CLK, RESET            : clock and asynchronous active-high reset
//   REQn_RD_ADDR/START    : requester n burst start address and one-cycle start pulse
//   REQn_READY            : requester n may issue a new burst (registered, = ~pend[n])
//   REQn_RD_DATA/_VALID   : read data copy and beat valid, valid only for the burst owner
//   DMA_RD_ADDR/START     : burst address (held for the burst) and one-cycle start to the DMA
//   DMA_READY             : DMA idle
//   DMA_RD_DATA/_VALID    : read beats from the DMA
//   PROTO_ERR             : sticky, START seen while that requester was not ready
//   STRAY_DATA            : sticky, DMA beat seen while no burst was outstanding
module lcd_dma_read_arbiter #(
    parameter int BURST_BEATS    = 8,
    parameter bit FIXED_PRIORITY = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [29:0] REQ0_RD_ADDR,
    input  logic        REQ0_START,
    output logic        REQ0_READY,
    output logic [31:0] REQ0_RD_DATA,
    output logic        REQ0_RD_DATA_VALID,
    input  logic [29:0] REQ1_RD_ADDR,
    input  logic        REQ1_START,
    output logic        REQ1_READY,
    output logic [31:0] REQ1_RD_DATA,
    output logic        REQ1_RD_DATA_VALID,
    output logic [29:0] DMA_RD_ADDR,
    output logic        DMA_START,
    input  logic        DMA_READY,
    input  logic [31:0] DMA_RD_DATA,
    input  logic        DMA_RD_DATA_VALID,
    output logic        PROTO_ERR,
    output logic        STRAY_DATA
);

    localparam int                CNT_W     = $clog2(BURST_BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_MAX = CNT_W'(BURST_BEATS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [1:0]       pend_q,       pend_d;
    logic [1:0]       ready_q,      ready_d;
    logic [29:0]      addr0_q,      addr0_d;
    logic [29:0]      addr1_q,      addr1_d;
    logic [29:0]      dma_rd_addr_q, dma_rd_addr_d;
    logic             dma_start_q,  dma_start_d;
    logic             owner_q,      owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic             proto_err_q,  proto_err_d;
    logic             stray_data_q, stray_data_d;

    logic             winner;
    logic             other_req;
    logic             burst_done;

    // Winner among pending requesters, evaluated from registered pend only.
    // ~pend_q[0] picks 0 when it is pending, otherwise the only other candidate.
    always_comb begin
        other_req = ~last_owner_q;
        winner    = ~pend_q[0];
        if (!FIXED_PRIORITY && pend_q[other_req]) begin
            winner = other_req;
        end
    end

    // DMA_START must already be low so the DMA_READY we see is its post-burst idle,
    // not the idle level it still shows in the cycle the burst was issued.
    assign burst_done = (beat_cnt_q == BEATS_MAX) && DMA_READY && !dma_start_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        addr0_d      = addr0_q;
        addr1_d      = addr1_q;
        dma_rd_addr_d = dma_rd_addr_q;
        dma_start_d  = dma_start_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        proto_err_d  = proto_err_q;
        stray_data_d = stray_data_q;

        case (state_q)
            ST_IDLE: begin
                dma_start_d = 1'b0;
                if (DMA_RD_DATA_VALID) begin
                    stray_data_d = 1'b1;
                end
                if ((pend_q != 2'b00) && DMA_READY) begin
                    dma_rd_addr_d = winner ? addr1_q : addr0_q;
                    dma_start_d   = 1'b1;
                    owner_d       = winner;
                    last_owner_d  = winner;
                    beat_cnt_d    = '0;
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                dma_start_d = 1'b0;
                if (DMA_RD_DATA_VALID && (beat_cnt_q != BEATS_MAX)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (burst_done) begin
                    pend_d[owner_q] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The owner is never ready, so a legal start cannot collide with the
        // pend clear above.
        if (REQ0_START) begin
            if (ready_q[0]) begin
                pend_d[0] = 1'b1;
                addr0_d   = REQ0_RD_ADDR;
            end else begin
                proto_err_d = 1'b1;
            end
        end
        if (REQ1_START) begin
            if (ready_q[1]) begin
                pend_d[1] = 1'b1;
                addr1_d   = REQ1_RD_ADDR;
            end else begin
                proto_err_d = 1'b1;
            end
        end

        ready_d = ~pend_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            pend_q        <= 2'b00;
            ready_q       <= 2'b11;
            addr0_q       <= '0;
            addr1_q       <= '0;
            dma_rd_addr_q <= '0;
            dma_start_q   <= 1'b0;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            beat_cnt_q    <= '0;
            proto_err_q   <= 1'b0;
            stray_data_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            ready_q       <= ready_d;
            addr0_q       <= addr0_d;
            addr1_q       <= addr1_d;
            dma_rd_addr_q <= dma_rd_addr_d;
            dma_start_q   <= dma_start_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            beat_cnt_q    <= beat_cnt_d;
            proto_err_q   <= proto_err_d;
            stray_data_q  <= stray_data_d;
        end
    end

    assign REQ0_READY  = ready_q[0];
    assign REQ1_READY  = ready_q[1];
    assign DMA_RD_ADDR = dma_rd_addr_q;
    assign DMA_START   = dma_start_q;
    assign PROTO_ERR   = proto_err_q;
    assign STRAY_DATA  = stray_data_q;

    // Data fans out to both; only the valid is steered to the burst owner.
    assign REQ0_RD_DATA       = DMA_RD_DATA;
    assign REQ1_RD_DATA       = DMA_RD_DATA;
    assign REQ0_RD_DATA_VALID = DMA_RD_DATA_VALID && (state_q == ST_BUSY) && (owner_q == 1'b0);
    assign REQ1_RD_DATA_VALID = DMA_RD_DATA_VALID && (state_q == ST_BUSY) && (owner_q == 1'b1);

endmodule

// File: tb/tb_lcd_dma_read_arbiter.sv
`timescale 1ns/1ps
// Bench for lcd_dma_read_arbiter: instance 0 is fixed priority, instance 1 round-robin.
// A spec-level model is stepped once per clock and compared against every output;
// directed tests add literal expectations on grant order, latency and sticky flags.
module tb_lcd_dma_read_arbiter;

    localparam int BB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // index [i] = instance, [n] = requester
    logic [1:0][1:0][29:0] req_addr;
    logic [1:0][1:0]       req_start;
    logic [1:0][1:0]       req_ready;
    logic [1:0][1:0][31:0] req_data;
    logic [1:0][1:0]       req_vld;
    logic [1:0][29:0]      d_addr;
    logic [1:0]            d_start;
    logic [1:0]            d_ready;
    logic [1:0][31:0]      d_data;
    logic [1:0]            d_vld;
    logic [1:0]            perr;
    logic [1:0]            stray;
    logic [1:0]            rsp_rdy;
    logic [1:0]            dma_hold;

    assign d_ready = rsp_rdy & ~dma_hold;

    lcd_dma_read_arbiter #(.BURST_BEATS(BB), .FIXED_PRIORITY(1'b1)) u_fix (
        .CLK(clk), .RESET(rst),
        .REQ0_RD_ADDR(req_addr[0][0]), .REQ0_START(req_start[0][0]), .REQ0_READY(req_ready[0][0]),
        .REQ0_RD_DATA(req_data[0][0]), .REQ0_RD_DATA_VALID(req_vld[0][0]),
        .REQ1_RD_ADDR(req_addr[0][1]), .REQ1_START(req_start[0][1]), .REQ1_READY(req_ready[0][1]),
        .REQ1_RD_DATA(req_data[0][1]), .REQ1_RD_DATA_VALID(req_vld[0][1]),
        .DMA_RD_ADDR(d_addr[0]), .DMA_START(d_start[0]), .DMA_READY(d_ready[0]),
        .DMA_RD_DATA(d_data[0]), .DMA_RD_DATA_VALID(d_vld[0]),
        .PROTO_ERR(perr[0]), .STRAY_DATA(stray[0])
    );

    lcd_dma_read_arbiter #(.BURST_BEATS(BB), .FIXED_PRIORITY(1'b0)) u_rr (
        .CLK(clk), .RESET(rst),
        .REQ0_RD_ADDR(req_addr[1][0]), .REQ0_START(req_start[1][0]), .REQ0_READY(req_ready[1][0]),
        .REQ0_RD_DATA(req_data[1][0]), .REQ0_RD_DATA_VALID(req_vld[1][0]),
        .REQ1_RD_ADDR(req_addr[1][1]), .REQ1_START(req_start[1][1]), .REQ1_READY(req_ready[1][1]),
        .REQ1_RD_DATA(req_data[1][1]), .REQ1_RD_DATA_VALID(req_vld[1][1]),
        .DMA_RD_ADDR(d_addr[1]), .DMA_START(d_start[1]), .DMA_READY(d_ready[1]),
        .DMA_RD_DATA(d_data[1]), .DMA_RD_DATA_VALID(d_vld[1]),
        .PROTO_ERR(perr[1]), .STRAY_DATA(stray[1])
    );

    // ---------------- DMA responder (one per instance, driven on negedge) ----------------
    int left [2];
    int gap  [2];

    initial begin
        rsp_rdy = 2'b11;
        d_vld   = '0;
        d_data  = '0;
        left    = '{0, 0};
        gap     = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                d_vld[i] = 1'b0;
                if (left[i] > 0) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        d_vld[i]  = 1'b1;
                        d_data[i] = $urandom();
                        left[i]--;
                    end
                end else if (d_start[i]) begin
                    rsp_rdy[i] = 1'b0;
                    left[i]    = BB;
                    gap[i]     = 1;
                end else begin
                    rsp_rdy[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]       m_pend  [2];
    logic [1:0][29:0] m_addr  [2];
    int               m_cur   [2];   // -1 = no burst outstanding, else owner
    int               m_last  [2];
    logic             m_start [2];
    logic [29:0]      m_daddr [2];
    int               m_beats [2];
    logic             m_perr  [2];
    logic             m_stray [2];

    logic [29:0] g0[$];
    logic [29:0] g1[$];
    int          vcnt [2][2];

    // Advance the model by one clock edge. Inputs only change on negedge, so the
    // values seen now are the ones the edge just consumed.
    task automatic model_step(int i);
        logic [1:0] p;
        int         w;
        logic       done;
        if (rst) begin
            m_pend[i]  = 2'b00;
            m_addr[i]  = '0;
            m_cur[i]   = -1;
            m_last[i]  = 1;
            m_start[i] = 1'b0;
            m_daddr[i] = '0;
            m_beats[i] = 0;
            m_perr[i]  = 1'b0;
            m_stray[i] = 1'b0;
            return;
        end
        p = m_pend[i];
        if (m_cur[i] < 0) begin
            m_start[i] = 1'b0;
            if (d_vld[i]) m_stray[i] = 1'b1;
            if (m_pend[i] != 2'b00 && d_ready[i]) begin
                if (i == 0) begin
                    w = m_pend[i][0] ? 0 : 1;
                end else begin
                    w = 1 - m_last[i];
                    if (!m_pend[i][w]) w = 1 - w;
                end
                m_daddr[i] = m_addr[i][w];
                m_start[i] = 1'b1;
                m_cur[i]   = w;
                m_last[i]  = w;
                m_beats[i] = 0;
            end
        end else begin
            done = (m_beats[i] == BB) && d_ready[i] && !m_start[i];
            if (d_vld[i] && m_beats[i] < BB) m_beats[i]++;
            m_start[i] = 1'b0;
            if (done) begin
                p[m_cur[i]] = 1'b0;
                m_cur[i]    = -1;
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (req_start[i][n]) begin
                if (!m_pend[i][n]) begin
                    p[n]         = 1'b1;
                    m_addr[i][n] = req_addr[i][n];
                end else begin
                    m_perr[i] = 1'b1;
                end
            end
        end
        m_pend[i] = p;
    endtask

    task automatic model_check(int i);
        chk($sformatf("dma_start%0d", i), d_start[i], m_start[i]);
        chk($sformatf("dma_addr%0d", i), d_addr[i], m_daddr[i]);
        chk($sformatf("proto_err%0d", i), perr[i], m_perr[i]);
        chk($sformatf("stray%0d", i), stray[i], m_stray[i]);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("ready%0d_%0d", i, n), req_ready[i][n], !m_pend[i][n]);
            chk($sformatf("rd_data%0d_%0d", i, n), req_data[i][n], d_data[i]);
            chk($sformatf("rd_valid%0d_%0d", i, n), req_vld[i][n], d_vld[i] && (m_cur[i] == n));
        end
    endtask

    // Single compare process: step, check, then record grants and routed beats.
    initial begin
        vcnt = '{'{0, 0}, '{0, 0}};
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                model_check(i);
                if (d_start[i]) begin
                    if (i == 0) g0.push_back(d_addr[i]);
                    else        g1.push_back(d_addr[i]);
                end
                for (int n = 0; n < 2; n++) if (req_vld[i][n]) vcnt[i][n]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(int i, int n, logic [29:0] a);
        @(negedge clk);
        req_addr[i][n]  = a;
        req_start[i][n] = 1'b1;
        @(negedge clk);
        req_start[i][n] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int n = 0;
        while (!(req_ready[i] == 2'b11 && left[i] == 0 && rsp_rdy[i] && !d_start[i]) && n < 200) begin
            step();
            n++;
        end
        chk($sformatf("idle_timeout%0d", i), n < 200, 1);
    endtask

    function automatic logic [29:0] grant_at(int i, int k);
        if (i == 0) return (k < g0.size()) ? g0[k] : 30'h3FFF_FFFF;
        return (k < g1.size()) ? g1[k] : 30'h3FFF_FFFF;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        int base;
        int issued [2];
        req_addr  = '0;
        req_start = '0;
        dma_hold  = '0;

        // reset state
        repeat (3) step();
        chk("rst_ready", req_ready[0], 2'b11);
        chk("rst_dma_start", d_start[0], 0);
        chk("rst_dma_addr", d_addr[0], 0);
        chk("rst_proto", perr[0], 0);
        chk("rst_stray", stray[1], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();

        // single burst, fixed-priority instance
        base = g0.size();
        pulse(0, 0, 30'h1000_0000);
        #1;
        chk("t1_no_start_at_latch", d_start[0], 0);
        chk("t1_ready_low", req_ready[0][0], 0);
        step();
        chk("t1_start", d_start[0], 1);
        chk("t1_addr", d_addr[0], 30'h1000_0000);
        n = 0;
        while (!req_ready[0][0] && n < 40) begin
            step();
            n++;
            if (!req_ready[0][0]) chk("t1_addr_held", d_addr[0], 30'h1000_0000);
        end
        chk("t1_ready_latency", n, 11);
        chk("t1_beats_req0", vcnt[0][0], 8);
        chk("t1_beats_req1", vcnt[0][1], 0);
        wait_idle(0);

        // simultaneous starts, fixed priority
        base = g0.size();
        @(negedge clk);
        req_addr[0][0] = 30'h100; req_start[0][0] = 1'b1;
        req_addr[0][1] = 30'h200; req_start[0][1] = 1'b1;
        @(negedge clk);
        req_start[0] = 2'b00;
        n = 0;
        while (!req_ready[0][0] && n < 40) begin step(); n++; end
        chk("t2_req1_still_busy", req_ready[0][1], 0);
        wait_idle(0);
        chk("t2_grants", g0.size() - base, 2);
        chk("t2_first", grant_at(0, base), 30'h100);
        chk("t2_second", grant_at(0, base + 1), 30'h200);
        chk("t2_beats_req1", vcnt[0][1], 8);

        // protocol error: second start while not ready must not disturb the address
        base = g0.size();
        chk("t3_proto_before", perr[0], 0);
        @(negedge clk);
        req_addr[0][1] = 30'h300; req_start[0][1] = 1'b1;
        @(negedge clk);
        req_addr[0][1] = 30'h3FF;
        @(negedge clk);
        req_start[0][1] = 1'b0;
        #1;
        chk("t3_proto_set", perr[0], 1);
        wait_idle(0);
        chk("t3_grants", g0.size() - base, 1);
        chk("t3_addr", grant_at(0, base), 30'h300);

        // DMA busy gate
        @(negedge clk);
        dma_hold[0] = 1'b1;
        pulse(0, 0, 30'h400);
        n = 0;
        repeat (10) begin
            step();
            if (d_start[0]) n++;
        end
        chk("t4_no_start_while_busy", n, 0);
        @(negedge clk);
        dma_hold[0] = 1'b0;
        step();
        chk("t4_start_after_release", d_start[0], 1);
        chk("t4_addr", d_addr[0], 30'h400);
        wait_idle(0);

        // round-robin: both re-request immediately, two bursts each
        base = g1.size();
        issued = '{0, 0};
        n = 0;
        while ((issued[0] < 2 || issued[1] < 2) && n < 300) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                req_start[1][r] = req_ready[1][r] && (issued[r] < 2);
                if (req_start[1][r]) begin
                    req_addr[1][r] = (r == 0) ? 30'h0A0 : 30'h0B0;
                    issued[r]++;
                end
            end
            n++;
        end
        @(negedge clk);
        req_start[1] = 2'b00;
        wait_idle(1);
        wait_idle(1);
        chk("t5_grants", g1.size() - base, 4);
        chk("t5_g0", grant_at(1, base),     30'h0A0);
        chk("t5_g1", grant_at(1, base + 1), 30'h0B0);
        chk("t5_g2", grant_at(1, base + 2), 30'h0A0);
        chk("t5_g3", grant_at(1, base + 3), 30'h0B0);

        // reset in the middle of a burst
        base = vcnt[1][0];
        pulse(1, 0, 30'h55);
        n = 0;
        while ((vcnt[1][0] - base) < 3 && n < 40) begin step(); n++; end
        chk("t6_three_beats", vcnt[1][0] - base, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ready", req_ready[1], 2'b11);
        chk("t6_dma_start", d_start[1], 0);
        chk("t6_dma_addr", d_addr[1], 0);
        chk("t6_valid", req_vld[1], 2'b00);
        chk("t6_proto_cleared", perr[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle(1);
        step();
        chk("t6_stray", stray[1], 1);
        chk("t6_no_more_beats", vcnt[1][0] - base, 3);
        chk("t6_stray_other", stray[0], 0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
